// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory request controller.
// The bench also imports this package to see the FSM encodings.
package imem_ctrl_pkg;

  localparam int IMEM_ADDR_WIDTH  = 32;
  localparam int IMEM_INSTR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } imem_state_e;

  function automatic logic word_aligned(input logic [1:0] addr_lsbs);
    return addr_lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/imem_ctrl_rsp_buf.sv
// One-entry tagged response buffer. It keeps the last returned word so that
// IF stalls and short backward redirects can be served without a bus access.
module imem_ctrl_rsp_buf #(
  parameter int ADDR_WIDTH  = imem_ctrl_pkg::IMEM_ADDR_WIDTH,
  parameter int INSTR_WIDTH = imem_ctrl_pkg::IMEM_INSTR_WIDTH
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  input  logic                   load,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH-1:0]  lookup_addr,
  input  logic [ADDR_WIDTH-1:0]  probe_addr,
  output logic                   lookup_hit,
  output logic [INSTR_WIDTH-1:0] lookup_data,
  output logic                   probe_hit
);

  logic                   buf_valid;
  logic [ADDR_WIDTH-1:0]  buf_addr;
  logic [INSTR_WIDTH-1:0] buf_data;

  // NOTE: the data word is reset along with its tag so the output is never X;
  // buf_valid alone already prevents a stale word from being delivered.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_addr  <= load_addr;
      buf_data  <= load_data;
    end
  end

  assign lookup_hit  = buf_valid && (buf_addr == lookup_addr);
  assign lookup_data = buf_data;
  assign probe_hit   = buf_valid && (buf_addr == probe_addr);

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory request controller upstream of IF: turns next_pc into
// req/gnt/rvalid bus requests and returns words aligned to the IF pc.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = IMEM_ADDR_WIDTH,
  parameter int INSTR_WIDTH = IMEM_INSTR_WIDTH
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  input  logic [ADDR_WIDTH-1:0]  boot_addr,
  input  logic [ADDR_WIDTH-1:0]  next_pc,
  output logic                   instr_read_data_valid,
  output logic [INSTR_WIDTH-1:0] instr_read_data,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata
);

  imem_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic [ADDR_WIDTH-1:0]  out_addr;
  logic                   rsp_accept;
  logic                   need;
  logic                   issue;
  logic                   cur_hit;
  logic                   next_hit;
  logic [INSTR_WIDTH-1:0] buf_data;

  // rvalid only counts while a request is outstanding, so a late response
  // straddling a reset is dropped.
  assign rsp_accept = (state_q == RSP) && imem_rvalid;

  // The word arriving this cycle is loaded into the buffer at the edge, so it
  // also satisfies a next_pc that equals its address (IF stalled on it).
  assign need  = !(next_hit || (rsp_accept && (out_addr == next_pc)));
  assign issue = !cpu_rst && need && word_aligned(next_pc[1:0])
                 && ((state_q == IDLE) || rsp_accept);

  imem_ctrl_rsp_buf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_rsp_buf (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .load       (rsp_accept),
    .load_addr  (out_addr),
    .load_data  (imem_rdata),
    .lookup_addr(cur_addr),
    .probe_addr (next_pc),
    .lookup_hit (cur_hit),
    .lookup_data(buf_data),
    .probe_hit  (next_hit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q  <= IDLE;
      cur_addr <= boot_addr;
      out_addr <= '0;
    end else begin
      state_q  <= state_d;
      cur_addr <= next_pc;
      if (issue) out_addr <= next_pc;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (issue) state_d = imem_gnt ? RSP : REQ;
      REQ:     if (imem_gnt) state_d = RSP;
      RSP:     if (imem_rvalid) state_d = issue ? (imem_gnt ? RSP : REQ) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req              = 1'b0;
    imem_addr             = '0;
    instr_read_data_valid = 1'b0;
    instr_read_data       = '0;

    // Address is held from out_addr while waiting for gnt, whatever next_pc does.
    if (issue) begin
      imem_req  = 1'b1;
      imem_addr = next_pc;
    end else if (state_q == REQ) begin
      imem_req  = 1'b1;
      imem_addr = out_addr;
    end

    // A response tagged with a different address than the IF pc is stale
    // (redirect in flight) and is only buffered, never delivered.
    if (rsp_accept && (out_addr == cur_addr)) begin
      instr_read_data_valid = 1'b1;
      instr_read_data       = imem_rdata;
    end else if (cur_hit) begin
      instr_read_data_valid = 1'b1;
      instr_read_data       = buf_data;
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: a per-cycle vector table drives IF/bus inputs
// and queues expected requests and deliveries; a negedge monitor checks them.
module tb_imem_ctrl;
  import imem_ctrl_pkg::*;

  localparam int AW = IMEM_ADDR_WIDTH;
  localparam int IW = IMEM_INSTR_WIDTH;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic [AW-1:0] boot_addr;
  logic [AW-1:0] next_pc;
  logic          instr_read_data_valid;
  logic [IW-1:0] instr_read_data;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;

  imem_ctrl dut (
    .cpu_clk              (cpu_clk),
    .cpu_rst              (cpu_rst),
    .boot_addr            (boot_addr),
    .next_pc              (next_pc),
    .instr_read_data_valid(instr_read_data_valid),
    .instr_read_data      (instr_read_data),
    .imem_req             (imem_req),
    .imem_addr            (imem_addr),
    .imem_gnt             (imem_gnt),
    .imem_rvalid          (imem_rvalid),
    .imem_rdata           (imem_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [AW-1:0] req_q[$];
  logic [IW-1:0] rsp_q[$];

  // Bus memory model: one pending response with a countdown to rvalid.
  bit            pend_valid = 1'b0;
  logic [AW-1:0] pend_addr  = '0;
  int            pend_cnt   = 0;

  function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string detail);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // Monitor: pops an expectation whenever the DUT presents a request or a word.
  always @(negedge cpu_clk) begin
    if (cpu_rst) begin
      check("rst_imem_req",   64'(imem_req),              64'd0);
      check("rst_imem_addr",  64'(imem_addr),             64'd0);
      check("rst_valid",      64'(instr_read_data_valid), 64'd0);
      check("rst_data",       64'(instr_read_data),       64'd0);
    end
    if (imem_req) begin
      if (req_q.size() > 0) check("imem_addr", 64'(imem_addr), 64'(req_q.pop_front()));
      else flag("unexpected_req", $sformatf("got addr %0h expected no request", imem_addr));
    end
    if (req_q.size() > 0) begin
      flag("missing_req", $sformatf("got no request expected addr %0h", req_q[0]));
      req_q.delete();
    end
    if (instr_read_data_valid) begin
      if (rsp_q.size() > 0) check("instr_data", 64'(instr_read_data), 64'(rsp_q.pop_front()));
      else flag("unexpected_valid", $sformatf("got data %0h expected valid=0", instr_read_data));
    end
    if (rsp_q.size() > 0) begin
      flag("missing_valid", $sformatf("got valid=0 expected data %0h", rsp_q[0]));
      rsp_q.delete();
    end
  end

  // One clock cycle: rst, next_pc, gnt, response latency for a grant this
  // cycle, expected request (er/ra) and expected delivered address (ev/va).
  task automatic cyc(input bit rst, input logic [AW-1:0] npc, input bit g, input int lat,
                     input bit er, input logic [AW-1:0] ra,
                     input bit ev, input logic [AW-1:0] va);
    cpu_rst     = rst;
    next_pc     = npc;
    imem_gnt    = g;
    imem_rvalid = pend_valid && (pend_cnt == 0);
    imem_rdata  = imem_rvalid ? word(pend_addr) : '0;
    if (er) req_q.push_back(ra);
    if (ev) rsp_q.push_back(word(va));
    @(negedge cpu_clk);
    if (imem_rvalid) pend_valid = 1'b0;
    else if (pend_valid) pend_cnt--;
    if (imem_req && imem_gnt) begin
      pend_valid = 1'b1;
      pend_addr  = imem_addr;
      pend_cnt   = lat - 1;
    end
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    cpu_rst     = 1'b1;
    boot_addr   = '0;
    next_pc     = '0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    @(posedge cpu_clk);
    #1;
    //   rst npc         gnt lat er req         ev deliver
    cyc(1, 32'h0000,   1, 1, 0, 32'h0,     0, 32'h0);
    cyc(1, 32'h0000,   1, 1, 0, 32'h0,     0, 32'h0);
    // Sequential stream from boot: one request and one word per cycle.
    cyc(0, 32'h0000,   1, 1, 1, 32'h0000,  0, 32'h0);
    cyc(0, 32'h0004,   1, 1, 1, 32'h0004,  1, 32'h0000);
    cyc(0, 32'h0008,   1, 1, 1, 32'h0008,  1, 32'h0004);
    // Stall on 0x8 for three cycles: pass-through then buffer, no bus traffic.
    cyc(0, 32'h0008,   1, 1, 0, 32'h0,     1, 32'h0008);
    cyc(0, 32'h0008,   1, 1, 0, 32'h0,     1, 32'h0008);
    cyc(0, 32'h000C,   1, 1, 1, 32'h000C,  1, 32'h0008);
    // gnt withheld two cycles while next_pc moves 0x10 -> 0x80.
    cyc(0, 32'h0010,   0, 1, 1, 32'h0010,  1, 32'h000C);
    cyc(0, 32'h0080,   0, 1, 1, 32'h0010,  0, 32'h0);
    cyc(0, 32'h0080,   1, 1, 1, 32'h0010,  0, 32'h0);
    cyc(0, 32'h0080,   1, 1, 1, 32'h0080,  0, 32'h0);
    // 0x80 delivered; 0x84 issued with 4-cycle response latency.
    cyc(0, 32'h0084,   1, 4, 1, 32'h0084,  1, 32'h0080);
    cyc(0, 32'h0084,   1, 1, 0, 32'h0,     0, 32'h0);
    cyc(0, 32'h0084,   1, 1, 0, 32'h0,     0, 32'h0);
    cyc(0, 32'h0084,   1, 1, 0, 32'h0,     0, 32'h0);
    // 0x84 arrives while IF jumps to a misaligned target: nothing issued.
    cyc(0, 32'h0102,   1, 1, 0, 32'h0,     1, 32'h0084);
    cyc(0, 32'h0102,   1, 1, 0, 32'h0,     0, 32'h0);
    // Trap redirect to the vector.
    cyc(0, 32'h0100,   1, 1, 1, 32'h0100,  0, 32'h0);
    cyc(0, 32'h0104,   1, 4, 1, 32'h0104,  1, 32'h0100);
    cyc(0, 32'h0100,   1, 1, 0, 32'h0,     0, 32'h0);
    cyc(0, 32'h0100,   1, 1, 0, 32'h0,     1, 32'h0100);
    // Reset while 0x104 is outstanding; its rvalid lands right after release.
    cyc(1, 32'h0100,   1, 1, 0, 32'h0,     0, 32'h0);
    cyc(0, 32'h0000,   1, 1, 1, 32'h0000,  0, 32'h0);
    cyc(0, 32'h0004,   1, 1, 1, 32'h0004,  1, 32'h0000);
    cyc(0, 32'h0004,   1, 1, 0, 32'h0,     1, 32'h0004);
    cyc(0, 32'h0004,   1, 1, 0, 32'h0,     1, 32'h0004);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
